// File: rtl/rx_packet_fifo.sv
// Receive endpoint: snoops the shared packet bus, keeps packets addressed to this node
// (or broadcast), and buffers their payloads in a first-word-fall-through FIFO.
module rx_packet_fifo #(
  parameter int DATA_W   = 16,
  parameter int ID_W     = 16,
  parameter int DEPTH    = 8,
  parameter int BCAST_EN = 1,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W+DATA_W-1:0]   rx_in,
  input  logic                     rx_valid,
  input  logic [ID_W-1:0]          id,
  input  logic                     clr,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     match_pulse,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] payload;
    logic [ID_W-1:0]   dst;
  } pkt_t;

  pkt_t              s1_pkt_q, s1_pkt_d;
  logic              s1_v_q, s1_v_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              match_pulse_q, match_pulse_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic match, pop, push, drop, is_full, is_bcast;

  assign is_full  = (level_q == LW'(DEPTH));
  assign is_bcast = (BCAST_EN != 0) && (&s1_pkt_q.dst);
  assign match    = s1_v_q && ((s1_pkt_q.dst == id) || is_bcast);
  assign pop      = (level_q != '0) && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = match && (!is_full || pop);
  assign drop     = match && is_full && !pop;

  always_comb begin
    s1_pkt_d      = pkt_t'(rx_in);
    s1_v_d        = rx_valid;
    match_pulse_d = match;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    level_d       = level_q;
    drop_d        = drop_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      drop_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
      if (drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pkt_q      <= '0;
      s1_v_q        <= 1'b0;
      match_pulse_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      drop_q        <= '0;
    end else begin
      s1_pkt_q      <= s1_pkt_d;
      s1_v_q        <= s1_v_d;
      match_pulse_q <= match_pulse_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
      drop_q        <= drop_d;
    end
  end

  // Storage is deliberately not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wptr_q] <= s1_pkt_q.payload;
  end

  assign rd_valid    = (level_q != '0);
  assign rd_data     = rd_valid ? mem_q[rptr_q] : '0;
  assign level       = level_q;
  assign full        = is_full;
  assign match_pulse = match_pulse_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_rx_packet_fifo.sv
// Directed bench for rx_packet_fifo: inputs change on the falling edge, outputs are
// checked on the falling edge, so the DUT sees stable inputs at each rising edge.
module tb_rx_packet_fifo;
  logic        clk, rst;
  logic [31:0] rx_in;
  logic        rx_valid;
  logic [15:0] id;
  logic        clr, rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        full, match_pulse;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  rx_packet_fifo #(.DATA_W(16), .ID_W(16), .DEPTH(8), .BCAST_EN(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_valid(rx_valid), .id(id), .clr(clr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .full(full), .match_pulse(match_pulse), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // Places one valid packet on the bus for exactly one rising edge.
  task automatic push_pkt(input logic [31:0] p);
    rx_in = p; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_in = '0; rx_valid = 1'b0; id = 16'h0005; clr = 1'b0; rd_ready = 1'b0;
    #12;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0 || match_pulse !== 1'b0) begin failures++; $display("FAIL reset_flags full=%0b mp=%0b exp=0,0", full, match_pulse); end
    checks++; if (rd_data !== 16'h0 || drop_count !== 8'd0) begin failures++; $display("FAIL reset_data rd_data=%h drop=%0d exp=0,0", rd_data, drop_count); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    push_pkt(32'hBEEF_0005);
    checks++; if (level !== 4'd0 || match_pulse !== 1'b0) begin failures++; $display("FAIL basic_e0 level=%0d mp=%0b exp=0,0", level, match_pulse); end
    cyc();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin failures++; $display("FAIL basic_data v=%0b data=%h exp=1,beef", rd_valid, rd_data); end
    checks++; if (level !== 4'd1 || match_pulse !== 1'b1) begin failures++; $display("FAIL basic_e1 level=%0d mp=%0b exp=1,1", level, match_pulse); end
    cyc();
    checks++; if (match_pulse !== 1'b0) begin failures++; $display("FAIL basic_pulse_width mp=%0b exp=0", match_pulse); end
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    checks++; if (level !== 4'd0 || rd_valid !== 1'b0) begin failures++; $display("FAIL basic_drain level=%0d v=%0b exp=0,0", level, rd_valid); end
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL basic_pop_empty level=%0d exp=0", level); end
  endtask

  task automatic test_filter();
    push_pkt(32'h1234_0007); cyc();
    checks++; if (level !== 4'd0 || match_pulse !== 1'b0) begin failures++; $display("FAIL filt_other_id level=%0d mp=%0b exp=0,0", level, match_pulse); end
    rx_in = 32'h1234_0005; rx_valid = 1'b0; cyc(); cyc();
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL filt_invalid level=%0d exp=0", level); end
    push_pkt(32'hAAAA_FFFF); cyc();
    checks++; if (level !== 4'd1 || rd_data !== 16'hAAAA) begin failures++; $display("FAIL filt_bcast level=%0d data=%h exp=1,aaaa", level, rd_data); end
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      rx_in = {16'(i), 16'h0005}; rx_valid = 1'b1; cyc();
    end
    rx_valid = 1'b0; cyc();
    checks++; if (full !== 1'b1 || level !== 4'd8) begin failures++; $display("FAIL ovf_full full=%0b level=%0d exp=1,8", full, level); end
    checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_data !== 16'(i)) begin failures++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, rd_data, 16'(i)); end
      cyc();
    end
    rd_ready = 1'b0;
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL ovf_empty level=%0d exp=0", level); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      rx_in = {16'h0100 + 16'(i), 16'h0005}; rx_valid = 1'b1; cyc();
    end
    rx_valid = 1'b0; cyc();
    checks++; if (level !== 4'd8 || drop_count !== 8'd2) begin failures++; $display("FAIL simul_fill level=%0d drop=%0d exp=8,2", level, drop_count); end
    push_pkt(32'h01FF_0005);
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    checks++; if (level !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL simul_level level=%0d full=%0b exp=8,1", level, full); end
    checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL simul_drop got=%0d exp=2", drop_count); end
    rd_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checks++; if (rd_data !== ((i == 8) ? 16'h01FF : 16'h0100 + 16'(i))) begin failures++; $display("FAIL simul_order idx=%0d got=%h", i, rd_data); end
      cyc();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        rx_in = {16'h0200 + 16'(r*6 + i), 16'h0005}; rx_valid = 1'b1; cyc();
      end
      rx_valid = 1'b0; cyc();
      checks++; if (level !== 4'd6) begin failures++; $display("FAIL wrap_level round=%0d got=%0d exp=6", r, level); end
      rd_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        checks++; if (rd_data !== 16'h0200 + 16'(r*6 + i)) begin failures++; $display("FAIL wrap_order round=%0d idx=%0d got=%h", r, i, rd_data); end
        cyc();
      end
      rd_ready = 1'b0;
      checks++; if (level !== 4'd0 || rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty round=%0d level=%0d", r, level); end
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 9; i++) begin
      rx_in = {16'h0300 + 16'(i), 16'h0005}; rx_valid = 1'b1; cyc();
    end
    rx_valid = 1'b0; cyc();
    rd_ready = 1'b1; cyc(); cyc(); cyc(); rd_ready = 1'b0;
    checks++; if (level !== 4'd5 || drop_count !== 8'd3) begin failures++; $display("FAIL clr_pre level=%0d drop=%0d exp=5,3", level, drop_count); end
    push_pkt(32'h0777_0005);
    clr = 1'b1; cyc(); clr = 1'b0;
    checks++; if (level !== 4'd0 || rd_valid !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL clr_post level=%0d v=%0b drop=%0d exp=0,0,0", level, rd_valid, drop_count); end
    cyc();
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL clr_s1_discard level=%0d exp=0", level); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 308; i++) begin
      rx_in = {16'(i), 16'h0005}; rx_valid = 1'b1; cyc();
    end
    rx_valid = 1'b0; cyc();
    checks++; if (drop_count !== 8'd255 || level !== 4'd8) begin failures++; $display("FAIL sat_drop drop=%0d level=%0d exp=255,8", drop_count, level); end
    checks++; if (rd_data !== 16'd0) begin failures++; $display("FAIL sat_head got=%h exp=0", rd_data); end
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      rx_in = {16'h0400 + 16'(i), 16'h0005}; rx_valid = 1'b1; cyc();
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || level !== 4'd0 || full !== 1'b0) begin failures++; $display("FAIL arst_fifo v=%0b level=%0d full=%0b exp=0,0,0", rd_valid, level, full); end
    checks++; if (rd_data !== 16'h0 || drop_count !== 8'd0 || match_pulse !== 1'b0) begin failures++; $display("FAIL arst_out data=%h drop=%0d mp=%0b", rd_data, drop_count, match_pulse); end
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    cyc(); cyc();
    checks++; if (level !== 4'd0 || match_pulse !== 1'b0) begin failures++; $display("FAIL arst_inflight level=%0d mp=%0b exp=0,0", level, match_pulse); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_clr();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
